// File: rtl/bch_rom_pkg.sv
// Shared defaults and state encoding for the BCH next-state ROM sequencer.
// Optional build macro used by the sequencer: BCH_ROM_REVERSE_EN.
package bch_rom_pkg;

  localparam int DEF_ROW_W    = 128;
  localparam int DEF_NUM_ROWS = 16;
  localparam int DEF_ADDR_W   = 5;
  localparam int IDX_W        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/bch_row_skid_buf.sv
// Two-entry FIFO holding {row_last, idx, data} beats between the ROM read
// port and the row consumer. Head entry is a register, so outputs are glitch-free.
module bch_row_skid_buf
  import bch_rom_pkg::*;
#(
  parameter int W = 1 + IDX_W + DEF_ROW_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   occ_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   occ_q, occ_d;

  // Occupancy next state; push together with pop leaves it unchanged
  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage and pointer update; storage cleared so the head reads zero out of reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= push_data_i;
        wp_q        <= ~wp_q;
      end
      if (pop_i) rp_q <= ~rp_q;
      occ_q <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rp_q];

endmodule

// File: rtl/bch_next_rom_seq.sv
// Sweeps the BCH t=8 next-state matrix ROM once per start pulse and streams
// each row over valid/ready. Reads are only issued when the skid buffer is
// guaranteed to have room for the returning data, so the ROM never stalls.
// Build macro BCH_ROM_REVERSE_EN: issue rows from the top address down to BASE_ADDR.
module bch_next_rom_seq
  import bch_rom_pkg::*;
#(
  parameter int ROW_W     = DEF_ROW_W,
  parameter int NUM_ROWS  = DEF_NUM_ROWS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_1x,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_rdaddr,
  input  logic [ROW_W-1:0]  rom_rd_q,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [ROW_W-1:0]  row_data,
  output logic [IDX_W-1:0]  row_idx,
  output logic              row_last
);

  localparam int CNT_W = $clog2(NUM_ROWS + 1);
  localparam int ENT_W = 1 + IDX_W + ROW_W;

  seq_state_t        state_q;
  logic              busy_q, done_q, inflight_q, cap_last_q;
  logic [IDX_W-1:0]  cap_idx_q;
  logic [CNT_W-1:0]  issue_cnt_q;

  logic [1:0]        occ;
  logic [ENT_W-1:0]  head;
  logic              pop, rd_en, issue_last;
  logic [IDX_W-1:0]  issue_idx;

  assign row_valid = (occ != 2'd0);
  assign pop       = row_valid & row_ready;
  assign {row_last, row_idx, row_data} = head;

  // Read window: issue only if the buffer, counting the read in flight and
  // this cycle's pop, will still have a free slot when the data returns
  always_comb begin
    rd_en = (state_q == RUN) && (issue_cnt_q < CNT_W'(NUM_ROWS)) &&
            (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
`ifdef BCH_ROM_REVERSE_EN
    issue_idx = IDX_W'(NUM_ROWS - 1) - IDX_W'(issue_cnt_q);
`else
    issue_idx = IDX_W'(issue_cnt_q);
`endif
    issue_last = (issue_cnt_q == CNT_W'(NUM_ROWS - 1));
  end

  assign rom_rd_en  = rd_en;
  assign rom_rdaddr = rd_en ? (ADDR_W'(BASE_ADDR) + ADDR_W'(issue_idx)) : '0;
  assign busy       = busy_q;
  assign done       = done_q;

  // Sweep control FSM plus capture tag for the read in flight
  always_ff @(posedge clk_1x) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
      cap_last_q  <= 1'b0;
      cap_idx_q   <= '0;
      issue_cnt_q <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd_en;
      if (rd_en) begin
        cap_idx_q   <= issue_idx;
        cap_last_q  <= issue_last;
        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      end
      case (state_q)
        // a start landing on the done cycle is dropped, not queued
        IDLE: if (start && !done_q) begin
          state_q     <= RUN;
          busy_q      <= 1'b1;
          issue_cnt_q <= '0;
        end
        RUN: if (rd_en && issue_last) state_q <= DRAIN;
        DRAIN: if (pop && row_last) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bch_row_skid_buf #(.W(ENT_W)) u_skid (
    .clk_i       (clk_1x),
    .rst_i       (rst),
    .push_i      (inflight_q),
    .push_data_i ({cap_last_q, cap_idx_q, rom_rd_q}),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (head)
  );

endmodule

// File: tb/tb_bch_next_rom_seq.sv
// Bench for bch_next_rom_seq: models the ROM, drives sweeps with directed and
// random backpressure, and scores every beat against the expected row order.
module tb_bch_next_rom_seq;

  localparam int ROW_W    = 128;
  localparam int NUM_ROWS = 16;
  localparam int ADDR_W   = 5;

  logic              clk_1x = 1'b0;
  logic              rst, start, row_ready;
  logic              busy, done, rom_rd_en, row_valid, row_last;
  logic [ADDR_W-1:0] rom_rdaddr;
  logic [ROW_W-1:0]  rom_rd_q, row_data;
  logic [3:0]        row_idx;

  always #5 clk_1x = ~clk_1x;

  bch_next_rom_seq dut (
    .clk_1x(clk_1x), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_rd_en(rom_rd_en), .rom_rdaddr(rom_rdaddr), .rom_rd_q(rom_rd_q),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .row_last(row_last)
  );

  // golden ROM image and 1-cycle registered read
  logic [ROW_W-1:0] img [NUM_ROWS];
  always @(posedge clk_1x)
    if (rom_rd_en) rom_rd_q <= (int'(rom_rdaddr) < NUM_ROWS) ? img[rom_rdaddr[3:0]] : '0;

  int errors = 0, checks = 0, cyc = 0;
  int issued, popped, done_cnt, first_rd, first_vld, last_cyc, done_cyc;
  logic [15:0]  first_msb;
  bit           hold_prev;
  logic [132:0] prev_beat;

  // row number delivered as the k-th beat of a sweep
  function automatic int ord(input int k);
`ifdef BCH_ROM_REVERSE_EN
    return NUM_ROWS - 1 - k;
`else
    return k;
`endif
  endfunction

  function automatic logic [15:0] msb_of(input int i);
    case (i)
      0:       return 16'h5C51;
      15:      return 16'h3519;
      default: return 16'(i * 4369) ^ 16'hA5A5;
    endcase
  endfunction

  function automatic logic [132:0] exp_beat(input int k);
    logic [3:0] id;
    if (k < 0 || k >= NUM_ROWS) return 'x;
    id = 4'(ord(k));
    return {(k == NUM_ROWS - 1), id, img[ord(k)]};
  endfunction

  task automatic chk(input string tag, input logic [135:0] o, input logic [135:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  // one clock: drive at negedge, sample just after, score this cycle's events
  task automatic cycle(input bit rdy, input bit st);
    @(negedge clk_1x);
    row_ready = rdy;
    start     = st;
    #1;
    cyc++;
    if (hold_prev) chk("hold", {row_valid, row_last, row_idx, row_data}, {1'b1, prev_beat});
    if (rom_rd_en) begin
      if (first_rd < 0) begin
        first_rd = cyc;
        chk("busy_run", busy, 1);
      end
      chk("addr", rom_rdaddr, ADDR_W'(ord(issued)));
      issued++;
    end
    if (row_valid && first_vld < 0) first_vld = cyc;
    if (row_valid && row_ready) begin
      if (popped == 0) first_msb = row_data[127:112];
      if (row_last && last_cyc < 0) last_cyc = cyc;
      chk("beat", {row_last, row_idx, row_data}, exp_beat(popped));
      popped++;
    end
    chk("occ_le2", ((issued - popped) <= 2), 1);
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      chk("busy_done", busy, 0);
    end
    hold_prev = row_valid && !row_ready;
    prev_beat = {row_last, row_idx, row_data};
  endtask

  task automatic clr_model();
    issued = 0; popped = 0; done_cnt = 0; hold_prev = 0;
    first_rd = -1; first_vld = -1; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk_1x);
    rst = 1; start = 0; row_ready = 0;
    @(negedge clk_1x);
    rst = 0;
    #1;
    hold_prev = 0;
    chk("rst_ctl", {busy, done, rom_rd_en, row_valid, row_last}, 0);
    chk("rst_addr", rom_rdaddr, 0);
    chk("rst_data", {row_idx, row_data}, 0);
  endtask

  // mode 0: ready high, 1: 10-cycle stall after first row, 2: random ready
  task automatic sweep(input int mode, input int extra_at, input bit timing);
    int cs, stall;
    clr_model();
    stall = 10;
    cycle(1'b1, 1'b1);
    cs = cyc;
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      bit r, s;
      case (mode)
        0: r = 1'b1;
        1: begin
          r = 1'b1;
          if (popped >= 1 && stall > 0) begin r = 1'b0; stall--; end
        end
        default: r = 1'($urandom_range(0, 1));
      endcase
      s = (extra_at > 0) && (cyc + 1 == cs + extra_at);
      cycle(r, s);
      if (mode == 1 && !r && stall < 7) chk("stall_rden", rom_rd_en, 0);
    end
    chk("done_seen", done_cnt, 1);
    repeat (25) cycle(1'b1, 1'b0);
    chk("beats", popped, NUM_ROWS);
    chk("issued", issued, NUM_ROWS);
    chk("one_done", done_cnt, 1);
    chk("idle_busy", busy, 0);
    if (timing) begin
      chk("t_rd", first_rd - cs, 1);
      chk("t_vld", first_vld - cs, 3);
      chk("t_last", last_cyc - cs, 18);
      chk("t_done", done_cyc - cs, 19);
`ifdef BCH_ROM_REVERSE_EN
      chk("row0_msb", first_msb, 16'h3519);
`else
      chk("row0_msb", first_msb, 16'h5C51);
`endif
    end
  endtask

  initial begin
    int saved;
    rst = 1; start = 0; row_ready = 0;
    for (int i = 0; i < NUM_ROWS; i++)
      img[i] = {msb_of(i), $urandom(), $urandom(), $urandom(), 16'($urandom())};
    clr_model();
    do_reset();

    sweep(0, -1, 1);   // full-rate sweep with latency checks
    sweep(1, -1, 0);   // backpressure stall
    sweep(0, 5, 0);    // start while busy is ignored
    sweep(0, 19, 0);   // start on the done cycle is ignored

    // reset while row 7 is pending
    clr_model();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 100 && popped < 7; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("row7_pending", {row_valid, row_idx}, {1'b1, 4'(ord(7))});
    do_reset();
    saved = issued;
    repeat (20) cycle(1'b1, 1'b0);
    chk("no_done_after_rst", done_cnt, 0);
    chk("no_issue_after_rst", issued, saved);
    sweep(0, -1, 1);

    repeat (3) sweep(2, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bch_next_rom_seq.md
Name: bch_next_rom_seq

Overview:
- Sequencer for the BCH t=8 normal-frame "next-state" matrix ROM (16 rows x 128 bits, 5-bit address, 1-cycle registered read).
- On a start pulse it sweeps every matrix row and streams each one to the parallel BCH LFSR update stage over a valid/ready interface.
- A 2-entry skid buffer absorbs the ROM latency under backpressure.
- Sits between the BCH encoder control FSM and the ROM; it is the only driver of the ROM's rd_en and rdaddr.

Parameters:
- ROW_W, 128, ROM row width.
- NUM_ROWS, 16, rows per sweep.
- ADDR_W, 5, ROM address width.
- BASE_ADDR, 0, address of row 0.

Ports:
- clk_1x  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a sweep. Ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last row handshake.
- rom_rd_en  out  1  ROM read strobe.
- rom_rdaddr  out  ADDR_W  ROM address.
- rom_rd_q  in  ROW_W  ROM data; valid the cycle after rom_rd_en.
- row_valid  out  1  row available.
- row_ready  in  1  consumer accepts the row.
- row_data  out  ROW_W  matrix row.
- row_idx  out  4  row index, 0..NUM_ROWS-1.
- row_last  out  1  high with the final row of a sweep.

Behaviour:
- Reset: busy, done, rom_rd_en, row_valid, row_last = 0; rom_rdaddr = 0; row_data = 0; row_idx = 0. Counters, buffer occupancy and inflight flag are cleared.
- Reset mid-sweep aborts the sweep. No done pulse. The next start restarts at row 0.
- FSM states:
  - IDLE: on start, go to RUN.
  - RUN: issue reads until NUM_ROWS have been issued, then go to DRAIN.
  - DRAIN: on the row_last handshake, pulse done and go to IDLE.
- Read issue:
  - rom_rd_en = (state==RUN) && issued<NUM_ROWS && (occ + inflight - pop) < 2, where pop = row_valid&row_ready.
  - rom_rdaddr = BASE_ADDR + issue_cnt.
  - rom_rd_en and rom_rdaddr are combinational from registered state plus row_ready.
- Capture: the cycle after rom_rd_en, rom_rd_q is written into the buffer tail with its index. inflight is a 1-bit flag.
- Output: the buffer head drives row_data, row_idx and row_last (registered). row_valid = occ != 0.
- Handshake rules:
  - Data and index are held stable while row_valid && !row_ready.
  - Simultaneous push and pop keeps occupancy unchanged.
- Timing:
  - start accepted at edge T.
  - First rom_rd_en in cycle T+1.
  - First row_valid in cycle T+3.
  - With row_ready held high, one row per cycle thereafter.
  - row_last in cycle T+18; done and busy=0 in cycle T+19.
- start coincident with the done cycle is ignored. Sweeps are never queued.

Optional Feature:
- Macro: BCH_ROM_REVERSE_EN.
- Defined: addresses are issued BASE_ADDR+NUM_ROWS-1 down to BASE_ADDR; row_idx counts 15..0; row_last is asserted with idx 0.
- Undefined: ascending order only; no down-count logic is synthesised.

Decomposition:
- Package bch_rom_pkg holds ROW_W/NUM_ROWS/ADDR_W defaults and the seq_state_t enum (IDLE, RUN, DRAIN).
- Sub-module bch_row_skid_buf: 2-entry FIFO of {row_last, idx, data} with push/pop/occ. It is the natural split.

Test Plan:
- Reset, then start with row_ready=1:
  - rom_rdaddr 0..15 on consecutive cycles.
  - row_valid first at T+3; row 0 data MSBs 16'h5C51; row 15 MSBs 16'h3519.
  - row_last at T+18; done at T+19.
- row_ready=0 from the second row for 10 cycles:
  - At most 2 rows buffered, rom_rd_en low, row_data stable.
  - All 16 rows delivered in order afterwards.
- start pulsed again at T+5 while busy: exactly 16 beats and one done.
- rst asserted while row 7 is pending:
  - All outputs 0 the next cycle, no done.
  - A new start begins at address 0.
- Random row_ready (50%) over 3 sweeps: rows match the golden ROM image, and no duplicates or drops.
- BCH_ROM_REVERSE_EN defined: addresses 15..0, first row MSBs 16'h3519, row_last with idx 0.
